// File: rtl/led_write_port_pkg.sv
// -----------------------------------------------------------------------------
// led_write_port_pkg
// Shared memory-map definitions for bus peripherals on the 9-bit address bus:
// bus command encodings, bus widths and the register offsets of the LED port.
//
// Contents:
//   mem_cmd_e   - bus command encoding (2'b11 is unused and decodes as MNONE)
//   ADDR_W      - bus address width
//   DATA_W      - bus data width
//   LED_W       - LED bank width
//   OFS_*       - register offsets relative to a peripheral base address
//   reg_offset  - address minus base, modulo the address space
// -----------------------------------------------------------------------------
package led_write_port_pkg;

   typedef enum logic [1:0] {
      MNONE  = 2'b00,
      MREAD  = 2'b01,
      MWRITE = 2'b10
   } mem_cmd_e;

   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned LED_W  = 8;

   localparam logic [ADDR_W-1:0] OFS_DATA  = 9'd0;
   localparam logic [ADDR_W-1:0] OFS_SET   = 9'd1;
   localparam logic [ADDR_W-1:0] OFS_CLR   = 9'd2;
   localparam logic [ADDR_W-1:0] OFS_TGL   = 9'd3;
   localparam logic [ADDR_W-1:0] OFS_BLINK = 9'd4;

   // Wraps modulo 2**ADDR_W, so a block placed near the top of the map still
   // decodes consistently with base + offset arithmetic.
   function automatic logic [ADDR_W-1:0] reg_offset(input logic [ADDR_W-1:0] addr,
                                                     input logic [ADDR_W-1:0] base);
      return addr - base;
   endfunction

endpackage

// File: rtl/blink_timer.sv
// -----------------------------------------------------------------------------
// blink_timer
// Free-running prescaler counting 0..BLINK_DIV-1 that inverts a phase flop
// each time it wraps. A synchronous clear restarts both at zero and takes
// priority over a wrap in the same cycle.
//
// Parameters:
//   BLINK_DIV - clock cycles per phase half-period (minimum 2)
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   clear   - synchronous restart of prescaler and phase
//   phase   - current blink phase
//   tick    - high in the last cycle of a half-period (prescaler about to wrap)
// -----------------------------------------------------------------------------
module blink_timer #(
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic phase,
   output logic tick
);

   localparam int unsigned     CNT_W    = $clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;
   logic             r_phase;
   logic             w_phase_d;
   logic             w_tick;

   assign w_tick = (r_cnt == CNT_LAST);

   always_comb begin
      w_cnt_d   = r_cnt + CNT_ONE;
      w_phase_d = r_phase;
      if (clear) begin
         w_cnt_d   = '0;
         w_phase_d = 1'b0;
      end else if (w_tick) begin
         w_cnt_d   = '0;
         w_phase_d = ~r_phase;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_d;
         r_phase <= w_phase_d;
      end
   end

   assign phase = r_phase;
   assign tick  = w_tick;

endmodule

// File: rtl/led_write_port.sv
// -----------------------------------------------------------------------------
// led_write_port
// Memory-mapped LED bank. Five registers at BASE_ADDR+0..+4:
//   +0 DATA  (R/W) load led_reg
//   +1 SET   (W)   led_reg |= wd
//   +2 CLR   (W)   led_reg &= ~wd
//   +3 TGL   (W)   led_reg ^= wd
//   +4 BLINK (R/W) load blink_mask, restart blink timer
// LEDs whose blink_mask bit is set are inverted while the blink phase is high.
//
// Parameters:
//   BASE_ADDR - address of the DATA register
//   BLINK_DIV - clock cycles per blink half-period (minimum 2)
// Ports:
//   clk         - clock, rising edge
//   reset_n     - asynchronous active-low reset
//   mem_cmd     - bus command (MNONE/MREAD/MWRITE, 2'b11 ignored)
//   mem_addr    - bus address
//   write_data  - bus write data, bits [7:0] used
//   read_data   - readback value, meaningful while read_enable is high
//   read_enable - claims the shared read bus (combinational)
//   wr_ack      - registered pulse the cycle after an accepted write
//   LEDR        - registered LED drive
// -----------------------------------------------------------------------------
module led_write_port
   import led_write_port_pkg::*;
#(
   parameter logic [8:0]  BASE_ADDR = 9'h100,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  mem_cmd,
   input  logic [8:0]  mem_addr,
   input  logic [15:0] write_data,
   output logic [15:0] read_data,
   output logic        read_enable,
   output logic        wr_ack,
   output logic [7:0]  LEDR
);

   logic [ADDR_W-1:0] w_off;
   logic [LED_W-1:0]  w_wd;
   logic              w_is_write;
   logic              w_is_read;
   logic              w_wr_hit;
   logic              w_blink_clr;
   logic              w_unused_wd;

   logic [LED_W-1:0]  r_led;
   logic [LED_W-1:0]  w_led_d;
   logic [LED_W-1:0]  r_mask;
   logic [LED_W-1:0]  w_mask_d;
   logic              r_wr_ack;
   logic [LED_W-1:0]  r_ledr;

   logic              w_phase;
   logic              w_tick;
   logic              w_phase_d;

   // ---------------------------------------------------------------------------
   // Address / command decode
   // ---------------------------------------------------------------------------
   assign w_off       = reg_offset(mem_addr, BASE_ADDR);
   assign w_wd        = write_data[LED_W-1:0];
   assign w_unused_wd = ^write_data[DATA_W-1:LED_W];
   assign w_is_write  = (mem_cmd == MWRITE);
   assign w_is_read   = (mem_cmd == MREAD);
   assign w_wr_hit    = w_is_write && (w_off <= OFS_BLINK);
   assign w_blink_clr = w_wr_hit && (w_off == OFS_BLINK);

   // ---------------------------------------------------------------------------
   // Register next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      w_led_d  = r_led;
      w_mask_d = r_mask;
      if (w_wr_hit) begin
         case (w_off)
            OFS_DATA:  w_led_d  = w_wd;
            OFS_SET:   w_led_d  = r_led | w_wd;
            OFS_CLR:   w_led_d  = r_led & ~w_wd;
            OFS_TGL:   w_led_d  = r_led ^ w_wd;
            OFS_BLINK: w_mask_d = w_wd;
            default:   ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Blink timer
   // ---------------------------------------------------------------------------
   blink_timer #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (w_blink_clr),
      .phase   (w_phase),
      .tick    (w_tick)
   );

   // Phase the timer will hold after this edge; LEDR is built from next-state
   // values so it matches the registers it is derived from.
   assign w_phase_d = !w_blink_clr && (w_phase ^ w_tick);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_led    <= '0;
         r_mask   <= '0;
         r_wr_ack <= 1'b0;
         r_ledr   <= '0;
      end else begin
         r_led    <= w_led_d;
         r_mask   <= w_mask_d;
         r_wr_ack <= w_wr_hit;
         r_ledr   <= w_led_d ^ (w_mask_d & {LED_W{w_phase_d}});
      end
   end

   // ---------------------------------------------------------------------------
   // Readback (combinational, zero latency)
   // ---------------------------------------------------------------------------
   assign read_enable = w_is_read && ((w_off == OFS_DATA) || (w_off == OFS_BLINK));

   always_comb begin
      read_data = '0;
      if (w_off == OFS_DATA) begin
         read_data = {8'h00, r_led};
      end else if (w_off == OFS_BLINK) begin
         read_data = {8'h00, r_mask};
      end
   end

   assign wr_ack = r_wr_ack;
   assign LEDR   = r_ledr;

endmodule

// File: doc/led_write_port.md
LED_WRITE_PORT -- requirements
Module: led_write_port

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 9'h100, address of the LED data register.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (minimum 2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_cmd  input  2  bus command (MNONE/MREAD/MWRITE; 2'b11 treated as MNONE).
REQ-006 SHALL have port mem_addr  input  9  bus address.
REQ-007 SHALL have port write_data  input  16  bus write data; only bits [7:0] used.
REQ-008 SHALL have port read_data  output  16  readback value, valid while read_enable=1.
REQ-009 SHALL have port read_enable  output  1  drive read_data onto the shared read bus.
REQ-010 SHALL have port wr_ack  output  1  one-cycle pulse after each accepted write.
REQ-011 SHALL have port LEDR  output  8  LED drive.

Function
REQ-012 SHALL decode addresses: BASE+0 DATA, BASE+1 SET, BASE+2 CLR, BASE+3 TGL, BASE+4 BLINK.
REQ-013 Write is accepted in any cycle with mem_cmd=MWRITE and mem_addr in BASE+0..BASE+4; it takes effect at that cycle's rising edge.
REQ-014 DATA write: led_reg <= wd[7:0]; SET: led_reg <= led_reg | wd[7:0]; CLR: led_reg <= led_reg & ~wd[7:0]; TGL: led_reg <= led_reg ^ wd[7:0].
REQ-015 BLINK write: blink_mask <= wd[7:0]; prescaler and blink_phase cleared to 0 at the same edge.
REQ-016 MWRITE held for N consecutive cycles SHALL apply the operation N times (TGL toggles every cycle).
REQ-017 MWRITE to any other address, MREAD, MNONE, 2'b11: no state change, no wr_ack.
REQ-018 wr_ack SHALL be registered: high exactly the cycle after each accepted write; back-to-back writes keep it high continuously.
REQ-019 read_enable SHALL be combinational: 1 iff mem_cmd=MREAD and mem_addr is BASE+0 or BASE+4; zero latency.
REQ-020 read_data SHALL be {8'h00, led_reg} at BASE+0, {8'h00, blink_mask} at BASE+4, 16'h0000 otherwise.
REQ-021 Prescaler SHALL count 0..BLINK_DIV-1; at BLINK_DIV-1 it wraps to 0 and blink_phase inverts; free-running.
REQ-022 LEDR SHALL be registered: LEDR <= next led_reg ^ (next blink_mask & {8{next blink_phase}}), i.e. LEDR reflects a write one edge after acceptance.
REQ-023 Prescaler wrap coinciding with a BLINK write: BLINK write wins (prescaler=0, phase=0).
REQ-024 blink_mask=0 SHALL yield LEDR=led_reg regardless of phase.

Reset
REQ-025 reset_n=0 SHALL immediately clear led_reg, blink_mask, prescaler, blink_phase, wr_ack and LEDR to 0, independent of clk.
REQ-026 A write whose edge coincides with reset_n=0 SHALL be discarded; no wr_ack after release.
REQ-027 read_enable/read_data remain combinational during reset and reflect cleared registers.

Structure
REQ-028 MNONE/MREAD/MWRITE and register offset constants SHALL live in the shared memory-map package used by all bus peripherals.
REQ-029 Prescaler plus phase flop SHALL be a sub-module blink_timer (inputs clk, reset_n, clear; output phase).
REQ-030 Prescaler width SHALL be $clog2(BLINK_DIV).

Verification (bench BLINK_DIV=4)
REQ-031 Reset, MWRITE BASE+0 wd=16'h00A5 -> wr_ack=1 next cycle, LEDR=8'hA5; MREAD BASE+0 -> read_enable=1, read_data=16'h00A5.
REQ-032 From 8'hA5: SET 8'h0F -> 8'hAF; CLR 8'hF0 -> 8'h0F; TGL 8'hFF held 2 cycles -> 8'h0F, wr_ack high 2 cycles.
REQ-033 led_reg=8'h00, BLINK wd=8'h81 -> LEDR 8'h00 for 4 cycles, 8'h81 for 4, repeating; MREAD BASE+4 -> 16'h0081.
REQ-034 MWRITE 9'h105 and 9'h140 wd=8'hFF -> LEDR unchanged, wr_ack=0; MREAD 9'h140 -> read_enable=0, read_data=0.
REQ-035 Assert reset_n mid-blink and mid-write -> all outputs 0 immediately; after release, LEDR=0 and no wr_ack.
